// File: rtl/postfix_emitter.sv
// Infix-to-postfix token converter (shunting-yard) with an operator stack of DEPTH entries.
// Define POSTFIX_EMITTER_ERR_EN to enable syntax/overflow detection and the sticky ERROR flag.
module postfix_emitter #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IN_NUMBER,
  input  logic       IN_NUMBER_STB,
  input  logic [7:0] IN_SIGN,
  input  logic       IN_SIGN_STB,
  output logic       BUSY,
  output logic [7:0] OUT_NUMBER,
  output logic       NUMBER_STB,
  output logic [7:0] OUT_SIGN,
  output logic       SIGN_STB,
  output logic       ERROR
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

`ifdef POSTFIX_EMITTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_SUB = 8'h2D;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_DIV = 8'h2F;
  localparam logic [7:0] CH_LPAR = 8'h28;
  localparam logic [7:0] CH_RPAR = 8'h29;
  localparam logic [7:0] CH_EQ = 8'h3D;

  typedef enum logic [2:0] {ACCEPT, POP, FLUSH, END, ERR} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sp_q, sp_d;
  logic [7:0]      stack_q [DEPTH];
  logic [7:0]      stack_d [DEPTH];
  logic [7:0]      op_q, op_d;
  logic [7:0]      out_number_q, out_number_d;
  logic [7:0]      out_sign_q, out_sign_d;
  logic            number_stb_q, number_stb_d;
  logic            sign_stb_q, sign_stb_d;
  logic            error_q, error_d;

  logic            empty;
  logic            full;
  logic [7:0]      top;
  logic            err_hit;

  // "(" and anything unknown rank lowest so it is never popped by an operator
  function automatic logic [1:0] prec(input logic [7:0] c);
    case (c)
      CH_MUL, CH_DIV: prec = 2'd2;
      CH_ADD, CH_SUB: prec = 2'd1;
      default:        prec = 2'd0;
    endcase
  endfunction

  assign empty = (sp_q == '0);
  assign full  = (sp_q == SW'(DEPTH));
  assign top   = stack_q[AW'(sp_q - SW'(1))];

  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    stack_d      = stack_q;
    op_d         = op_q;
    out_number_d = out_number_q;
    out_sign_d   = out_sign_q;
    number_stb_d = 1'b0;
    sign_stb_d   = 1'b0;
    error_d      = error_q;
    err_hit      = 1'b0;

    case (state_q)
      ACCEPT: begin
        if (IN_SIGN_STB) begin
          if (IN_NUMBER_STB && ERR_EN) begin
            err_hit = 1'b1;
          end else begin
            case (IN_SIGN)
              CH_ADD, CH_SUB, CH_MUL, CH_DIV, CH_RPAR: begin
                op_d    = IN_SIGN;
                state_d = POP;
              end
              CH_LPAR: begin
                if (full) begin
                  if (ERR_EN) err_hit = 1'b1;
                end else begin
                  stack_d[AW'(sp_q)] = CH_LPAR;
                  sp_d = sp_q + SW'(1);
                end
              end
              CH_EQ: state_d = FLUSH;
              default: begin
                if (ERR_EN) err_hit = 1'b1;
              end
            endcase
          end
        end else if (IN_NUMBER_STB) begin
          out_number_d = IN_NUMBER;
          number_stb_d = 1'b1;
        end
      end

      POP: begin
        if (op_q == CH_RPAR) begin
          if (empty) begin
            if (ERR_EN) err_hit = 1'b1;
            else        state_d = ACCEPT;
          end else if (top == CH_LPAR) begin
            sp_d    = sp_q - SW'(1);
            state_d = ACCEPT;
          end else begin
            sp_d       = sp_q - SW'(1);
            out_sign_d = top;
            sign_stb_d = 1'b1;
          end
        end else if (!empty && (prec(top) >= prec(op_q))) begin
          sp_d       = sp_q - SW'(1);
          out_sign_d = top;
          sign_stb_d = 1'b1;
        end else if (full) begin
          if (ERR_EN) err_hit = 1'b1;
          else        state_d = ACCEPT;
        end else begin
          stack_d[AW'(sp_q)] = op_q;
          sp_d    = sp_q + SW'(1);
          state_d = ACCEPT;
        end
      end

      FLUSH: begin
        // the end marker is registered on the way into END so it is visible during END
        if (empty) begin
          state_d      = END;
          out_number_d = 8'h00;
          out_sign_d   = CH_EQ;
          number_stb_d = 1'b1;
          sign_stb_d   = 1'b1;
        end else if (top == CH_LPAR) begin
          if (ERR_EN) err_hit = 1'b1;
          else        sp_d = sp_q - SW'(1);
        end else begin
          sp_d       = sp_q - SW'(1);
          out_sign_d = top;
          sign_stb_d = 1'b1;
        end
      end

      END: begin
        sp_d    = '0;
        state_d = ACCEPT;
      end

      default: state_d = state_q;
    endcase

    if (err_hit) begin
      state_d      = ERR;
      error_d      = 1'b1;
      number_stb_d = 1'b0;
      sign_stb_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ACCEPT;
      sp_q         <= '0;
      op_q         <= '0;
      out_number_q <= '0;
      out_sign_q   <= '0;
      number_stb_q <= 1'b0;
      sign_stb_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      op_q         <= op_d;
      out_number_q <= out_number_d;
      out_sign_q   <= out_sign_d;
      number_stb_q <= number_stb_d;
      sign_stb_q   <= sign_stb_d;
      error_q      <= error_d;
    end
  end

  // stack contents are only meaningful below sp_q, so they need no reset
  always_ff @(posedge CLK) begin
    stack_q <= stack_d;
  end

  assign BUSY       = (state_q != ACCEPT);
  assign OUT_NUMBER = out_number_q;
  assign NUMBER_STB = number_stb_q;
  assign OUT_SIGN   = out_sign_q;
  assign SIGN_STB   = sign_stb_q;
  assign ERROR      = error_q;

endmodule
